// File: rtl/d_cell_unit_if.sv
// ---------------------------------------------------------------------------
// d_cell_unit_if
//
// Purpose: data-memory port between d_cell_unit and the data memory wrapper.
//          The unit drives a registered request with direction, address and
//          write data; the memory answers with an acknowledge and read data.
//
// Signals:
//   d_req    unit -> mem  request, held until d_ack
//   d_dir    unit -> mem  0 = READ, 1 = WRITE
//   d_addr   unit -> mem  cell address (always the data pointer)
//   d_wdata  unit -> mem  write data (always the cached cell value)
//   d_ack    mem -> unit  transaction complete
//   d_rdata  mem -> unit  read data, valid in the d_ack cycle
//
// Modports: master (d_cell_unit side), slave (memory side).
// ---------------------------------------------------------------------------
interface d_cell_unit_if #(
  parameter int d_addr_width = 8
);
  logic                    d_req;
  logic                    d_dir;
  logic [d_addr_width-1:0] d_addr;
  logic [7:0]              d_wdata;
  logic                    d_ack;
  logic [7:0]              d_rdata;

  modport master (
    output d_req,
    output d_dir,
    output d_addr,
    output d_wdata,
    input  d_ack,
    input  d_rdata
  );

  modport slave (
    input  d_req,
    input  d_dir,
    input  d_addr,
    input  d_wdata,
    output d_ack,
    output d_rdata
  );
endinterface

// File: rtl/d_cell_unit.sv
// ---------------------------------------------------------------------------
// d_cell_unit
//
// Purpose: data-cell unit of the brainfuck CPU. Owns the data pointer and a
//          one-cell cache of the current cell. Cell operations (+ - > < ,)
//          become single-cycle cache updates or read/write transactions on
//          the data-memory port. Exposes the cached cell and a zero flag for
//          the loop and output instructions.
//
// Configuration macro: D_CELL_WRITEBACK_EN
//   defined   : write-back cache; memory is written only on RIGHT/LEFT/FLUSH
//               when the cell is dirty.
//   undefined : write-through; INC/DEC/SET write the cell immediately,
//               FLUSH behaves as NOP.
//
// Ports:
//   clk         in   single clock, posedge
//   rst         in   asynchronous active-high reset
//   op_req      in   core requests a cell operation (sampled only in IDLE)
//   op_code     in   0 INC, 1 DEC, 2 RIGHT, 3 LEFT, 4 SET, 5 FLUSH, 6-7 NOP
//   op_wdata    in   value for SET
//   op_ack      out  one-cycle pulse, operation complete
//   cell_value  out  cached value of the cell at the pointer
//   cell_zero   out  cell_value == 0
//   d_ptr       out  current data pointer
//   mem         master modport of d_cell_unit_if (data-memory port)
// ---------------------------------------------------------------------------
module d_cell_unit #(
  parameter int d_addr_width = 8,
  parameter int d_mem_length = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_req,
  input  logic [2:0]              op_code,
  input  logic [7:0]              op_wdata,
  output logic                    op_ack,
  output logic [7:0]              cell_value,
  output logic                    cell_zero,
  output logic [d_addr_width-1:0] d_ptr,
  d_cell_unit_if.master           mem
);

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_SET   = 3'd4;
  localparam logic [2:0] OP_FLUSH = 3'd5;

  localparam logic [d_addr_width-1:0] PTR_LAST = d_addr_width'(d_mem_length - 1);
  localparam logic [d_addr_width-1:0] PTR_ZERO = '0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_IDLE,
    S_WB,
    S_GAP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [d_addr_width-1:0] ptr_q, ptr_d;
  logic [7:0]              cell_q, cell_d;
  logic                    dirty_q, dirty_d;
  logic                    req_q, req_d;
  logic                    dir_q, dir_d;
  logic [2:0]              op_q, op_d;
  logic                    pending_q, pending_d;

  // State register; reset lands in FETCH so the cell at pointer 0 is loaded
  // before the first operation is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ptr_q     <= '0;
      cell_q    <= 8'h00;
      dirty_q   <= 1'b0;
      req_q     <= 1'b0;
      dir_q     <= DIR_READ;
      op_q      <= 3'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cell_q    <= cell_d;
      dirty_q   <= dirty_d;
      req_q     <= req_d;
      dir_q     <= dir_d;
      op_q      <= op_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic. d_req is registered, so it is raised on the transition
  // into WB or FETCH and dropped on the edge that samples d_ack; this leaves
  // at least one low cycle between back-to-back transactions, which the
  // memory needs because its ready flag lingers for a cycle.
  // pending marks that FETCH belongs to an operation and must end in DONE;
  // the post-reset fetch has it clear and returns to IDLE silently.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cell_d    = cell_q;
    dirty_d   = dirty_q;
    req_d     = req_q;
    dir_d     = dir_q;
    op_d      = op_q;
    pending_d = pending_q;

    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        dir_d = DIR_READ;
        if (req_q && mem.d_ack) begin
          cell_d  = mem.d_rdata;
          dirty_d = 1'b0;
          req_d   = 1'b0;
          state_d = pending_q ? S_DONE : S_IDLE;
        end
      end

      S_IDLE: begin
        if (op_req) begin
          op_d      = op_code;
          pending_d = 1'b1;
          case (op_code)
            OP_INC, OP_DEC, OP_SET: begin
              if (op_code == OP_INC) begin
                cell_d = cell_q + 8'd1;
              end else if (op_code == OP_DEC) begin
                cell_d = cell_q - 8'd1;
              end else begin
                cell_d = op_wdata;
              end
              dirty_d = 1'b1;
`ifdef D_CELL_WRITEBACK_EN
              state_d = S_DONE;
`else
              req_d   = 1'b1;
              dir_d   = DIR_WRITE;
              state_d = S_WB;
`endif
            end
            OP_RIGHT, OP_LEFT: begin
              if (dirty_q) begin
                req_d   = 1'b1;
                dir_d   = DIR_WRITE;
                state_d = S_WB;
              end else begin
                state_d = S_GAP;
              end
            end
            OP_FLUSH: begin
              if (dirty_q) begin
                req_d   = 1'b1;
                dir_d   = DIR_WRITE;
                state_d = S_WB;
              end else begin
                state_d = S_DONE;
              end
            end
            default: begin
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_WB: begin
        if (mem.d_ack) begin
          dirty_d = 1'b0;
          req_d   = 1'b0;
          state_d = (op_q == OP_RIGHT || op_q == OP_LEFT) ? S_GAP : S_DONE;
        end
      end

      // Pointer moves here, with d_req low, then the new cell is fetched.
      S_GAP: begin
        if (op_q == OP_RIGHT) begin
          ptr_d = (ptr_q == PTR_LAST) ? PTR_ZERO : ptr_q + 1'b1;
        end else begin
          ptr_d = (ptr_q == PTR_ZERO) ? PTR_LAST : ptr_q - 1'b1;
        end
        req_d   = 1'b1;
        dir_d   = DIR_READ;
        state_d = S_FETCH;
      end

      S_DONE: begin
        pending_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign op_ack      = (state_q == S_DONE);
  assign cell_value  = cell_q;
  assign cell_zero   = (cell_q == 8'h00);
  assign d_ptr       = ptr_q;

  assign mem.d_req   = req_q;
  assign mem.d_dir   = dir_q;
  assign mem.d_addr  = ptr_q;
  assign mem.d_wdata = cell_q;

endmodule

// File: tb/tb_d_cell_unit.sv
// ---------------------------------------------------------------------------
// tb_d_cell_unit
//
// Self-checking bench for d_cell_unit. A behavioural memory answers the
// data port with a configurable acknowledge delay and logs every completed
// transaction. A reference model tracks pointer, cell, dirty flag and memory
// image directly from the operation rules and predicts the transaction list
// and the op_ack latency of every operation. Follows D_CELL_WRITEBACK_EN.
// ---------------------------------------------------------------------------
module tb_d_cell_unit;

  localparam int MEM_LEN = 64;
  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;
`ifdef D_CELL_WRITEBACK_EN
  localparam bit WRITE_BACK = 1'b1;
`else
  localparam bit WRITE_BACK = 1'b0;
`endif

  typedef struct packed {
    logic       dir;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk;
  logic       rst;
  logic       op_req;
  logic [2:0] op_code;
  logic [7:0] op_wdata;
  logic       op_ack;
  logic [7:0] cell_value;
  logic       cell_zero;
  logic [7:0] d_ptr;

  d_cell_unit_if #(.d_addr_width(8)) mem_if ();

  d_cell_unit #(
    .d_addr_width(8),
    .d_mem_length(MEM_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_req     (op_req),
    .op_code    (op_code),
    .op_wdata   (op_wdata),
    .op_ack     (op_ack),
    .cell_value (cell_value),
    .cell_zero  (cell_zero),
    .d_ptr      (d_ptr),
    .mem        (mem_if)
  );

  int   checks;
  int   errors;
  int   ackDelay;
  logic [7:0] mem [MEM_LEN];
  txn_t logQ[$];
  txn_t expQ[$];

  int         mptr;
  logic [7:0] mcell;
  bit         mdirty;
  logic [7:0] marray [MEM_LEN];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder: ack arrives (1 + ackDelay) cycles after d_req is seen.
  task automatic serveRequest();
    txn_t t;
    bit   aborted;
    int   waits;
    t.dir   = mem_if.d_dir;
    t.addr  = mem_if.d_addr;
    t.data  = mem_if.d_wdata;
    aborted = 1'b0;
    waits   = ackDelay;
    for (int i = 0; i <= waits && !aborted; i++) begin
      @(posedge clk); #1;
      if (rst) begin
        aborted = 1'b1;
      end else begin
        checkOutput("hold_req", {31'd0, mem_if.d_req}, 32'd1);
        checkOutput("hold_cmd", {15'd0, mem_if.d_dir, mem_if.d_addr, mem_if.d_wdata},
                    {15'd0, t.dir, t.addr, t.data});
      end
    end
    if (!aborted) begin
      if (t.dir == DIR_READ) begin
        t.data = mem[t.addr[5:0]];
        mem_if.d_rdata = t.data;
      end else begin
        mem[t.addr[5:0]] = t.data;
      end
      mem_if.d_ack = 1'b1;
      logQ.push_back(t);
      @(posedge clk); #1;
      mem_if.d_ack = 1'b0;
      if (!rst) checkOutput("req_gap", {31'd0, mem_if.d_req}, 32'd0);
    end
  endtask

  initial begin
    mem_if.d_ack   = 1'b0;
    mem_if.d_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst && mem_if.d_req) serveRequest();
    end
  end

  task automatic pushExp(input logic dir, input int addr, input logic [7:0] data);
    txn_t t;
    t.dir  = dir;
    t.addr = 8'(addr);
    t.data = data;
    expQ.push_back(t);
  endtask

  task automatic modelWrite();
    pushExp(DIR_WRITE, mptr, mcell);
    marray[mptr] = mcell;
    mdirty = 1'b0;
  endtask

  // Reference model: applies one operation and returns the expected number
  // of cycles from acceptance to op_ack. Each memory transaction costs a
  // request cycle plus the ack cycle plus any stall; a move costs one more.
  task automatic modelOp(input logic [2:0] op, input logic [7:0] wd, output int lat);
    int n;
    int move;
    n = 0;
    move = 0;
    case (op)
      3'd0, 3'd1, 3'd4: begin
        if (op == 3'd0)      mcell = 8'((int'(mcell) + 1) % 256);
        else if (op == 3'd1) mcell = 8'((int'(mcell) + 255) % 256);
        else                 mcell = wd;
        if (WRITE_BACK) begin
          mdirty = 1'b1;
        end else begin
          modelWrite();
          n++;
        end
      end
      3'd2, 3'd3: begin
        if (mdirty) begin
          modelWrite();
          n++;
        end
        mptr  = (op == 3'd2) ? (mptr + 1) % MEM_LEN : (mptr + MEM_LEN - 1) % MEM_LEN;
        mcell = marray[mptr];
        pushExp(DIR_READ, mptr, mcell);
        n++;
        move = 1;
      end
      3'd5: begin
        if (mdirty) begin
          modelWrite();
          n++;
        end
      end
      default: begin
      end
    endcase
    lat = 1 + n * (2 + ackDelay) + move;
  endtask

  task automatic compareTxns();
    checkOutput("txn_count", logQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < logQ.size(); i++) begin
      checkOutput("txn", {15'd0, logQ[i]}, {15'd0, expQ[i]});
    end
    logQ.delete();
    expQ.delete();
  endtask

  task automatic checkState();
    checkOutput("cell_value", {24'd0, cell_value}, {24'd0, mcell});
    checkOutput("cell_zero", {31'd0, cell_zero}, {31'd0, (mcell == 8'h00)});
    checkOutput("d_ptr", {24'd0, d_ptr}, mptr);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] wd);
    int lat;
    int cnt;
    @(posedge clk); #1;
    checkOutput("ack_pulse", {31'd0, op_ack}, 32'd0);
    modelOp(op, wd, lat);
    op_req   = 1'b1;
    op_code  = op;
    op_wdata = wd;
    @(posedge clk); #1;
    op_req = 1'b0;
    cnt = 1;
    while (!op_ack && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("ack_latency", cnt, lat);
    checkState();
    compareTxns();
  endtask

  // Waits for the silent fetch after reset; no op_ack may appear.
  task automatic waitResetFetch();
    int cnt;
    int acks;
    cnt  = 0;
    acks = 0;
    while (logQ.size() < 1 && cnt < 50) begin
      @(posedge clk); #1;
      if (op_ack) acks++;
      cnt++;
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (op_ack) acks++;
    end
    checkOutput("reset_no_ack", acks, 32'd0);
    checkState();
    compareTxns();
  endtask

  initial begin
    int cnt;
    checks   = 0;
    errors   = 0;
    ackDelay = 0;
    rst      = 1'b1;
    op_req   = 1'b0;
    op_code  = 3'd6;
    op_wdata = 8'h00;
    for (int i = 0; i < MEM_LEN; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00;
    for (int i = 0; i < MEM_LEN; i++) marray[i] = mem[i];
    mptr   = 0;
    mcell  = 8'h00;
    mdirty = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_op_ack", {31'd0, op_ack}, 32'd0);
    checkOutput("rst_d_req", {31'd0, mem_if.d_req}, 32'd0);
    checkOutput("rst_d_dir", {31'd0, mem_if.d_dir}, {31'd0, DIR_READ});
    checkState();
    #4 rst = 1'b0;
    mcell = marray[0];
    pushExp(DIR_READ, 0, mcell);
    @(posedge clk); #1;
    checkOutput("req_first_edge", {31'd0, mem_if.d_req}, 32'd1);
    waitResetFetch();
    $display("[TB] reset fetch done");

    // INC x3, DEC x4 from zero ends at 0xFF
    repeat (3) applyStimulus(3'd0, 8'h00);
    repeat (4) applyStimulus(3'd1, 8'h00);
    checkOutput("wrap_ff", {24'd0, cell_value}, 32'hFF);

    // SET then RIGHT from pointer 0, then pointer wrap both ways
    applyStimulus(3'd4, 8'h41);
    applyStimulus(3'd2, 8'h00);
    applyStimulus(3'd3, 8'h00);
    applyStimulus(3'd3, 8'h00);
    checkOutput("wrap_left", {24'd0, d_ptr}, 32'd63);
    applyStimulus(3'd2, 8'h00);
    checkOutput("wrap_right", {24'd0, d_ptr}, 32'd0);

    // stalled memory acknowledge
    ackDelay = 5;
    applyStimulus(3'd4, 8'h5A);
    applyStimulus(3'd5, 8'h00);
    applyStimulus(3'd2, 8'h00);
    applyStimulus(3'd1, 8'h00);
    applyStimulus(3'd3, 8'h00);
    ackDelay = 0;
    $display("[TB] directed ops done");

    // randomized operations and stalls
    for (int k = 0; k < 150; k++) begin
      ackDelay = $urandom_range(0, 3);
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom));
    end
    ackDelay = 0;
    applyStimulus(3'd5, 8'h00);
    $display("[TB] random ops done");

    // reset asserted while a FETCH is outstanding
    ackDelay = 4;
    @(posedge clk); #1;
    op_req  = 1'b1;
    op_code = 3'd2;
    @(posedge clk); #1;
    op_req = 1'b0;
    cnt = 0;
    while (!(mem_if.d_req && mem_if.d_dir == DIR_READ) && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("fetch_started", {31'd0, mem_if.d_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("async_req_drop", {31'd0, mem_if.d_req}, 32'd0);
    checkOutput("async_ack_drop", {31'd0, op_ack}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_ptr", {24'd0, d_ptr}, 32'd0);
    #4;
    ackDelay = 0;
    rst = 1'b0;
    mptr   = 0;
    mdirty = 1'b0;
    mcell  = marray[0];
    pushExp(DIR_READ, 0, mcell);
    @(posedge clk); #1;
    checkOutput("refetch_req", {31'd0, mem_if.d_req}, 32'd1);
    checkOutput("refetch_addr", {24'd0, mem_if.d_addr}, 32'd0);
    checkOutput("refetch_dir", {31'd0, mem_if.d_dir}, {31'd0, DIR_READ});
    waitResetFetch();
    applyStimulus(3'd0, 8'h00);
    applyStimulus(3'd2, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_cell_unit.md
# d_cell_unit

Data-cell unit for the brainfuck CPU: it sits between the core's execute stage and the data memory wrapper, and owns the data pointer and a one-cell cache of the current cell. It turns the cell operations `+ - > < ,` into single-cycle cache updates or into read/write transactions on the data-memory port. It also exposes the current cell value and a zero flag for `[`, `]` and `.`.

## Interface
- `d_addr_width`, default 8: data pointer / memory address width.
- `d_mem_length`, default 64: number of cells; the pointer wraps inside `0..d_mem_length-1`; must be ≤ 2^`d_addr_width`.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `op_req`  in  1  core requests a cell operation.
- `op_code`  in  3  0 INC, 1 DEC, 2 RIGHT, 3 LEFT, 4 SET, 5 FLUSH, 6–7 NOP.
- `op_wdata`  in  8  value for SET.
- `op_ack`  out  1  one-cycle pulse: operation complete.
- `cell_value`  out  8  cached value of the cell at the pointer.
- `cell_zero`  out  1  `cell_value == 0`, combinational.
- `d_ptr`  out  `d_addr_width`  current data pointer.
- `d_req`  out  1  memory request, registered.
- `d_dir`  out  1  `DIRECTION_READ` / `DIRECTION_WRITE` from `macros/direction.vh`.
- `d_addr`  out  `d_addr_width`  memory address; always equals `d_ptr`.
- `d_wdata`  out  8  equals `cell_value`.
- `d_ack`  in  1  memory acknowledge.
- `d_rdata`  in  8  read data, valid in the `d_ack` cycle.

## Operation
- States: FETCH, IDLE, WB, GAP, DONE.
- Reset:
  - The FSM enters FETCH.
  - Pointer = 0, cell = 0, dirty = 0.
  - `op_ack` = 0, `d_req` = 0, `d_dir` = READ.
- FETCH:
  - Drive `d_req` = 1 with READ.
  - On `d_ack`: capture `d_rdata` into the cell, clear dirty, drop `d_req`.
  - Go to DONE if an op is pending, else IDLE. The post-reset fetch goes to IDLE with no `op_ack`.
- IDLE: accept `op_req` and latch `op_code`/`op_wdata`.
  - INC / DEC: cell ±1, modulo 256 (255+1 = 0, 0−1 = 255). Set dirty. Go to DONE.
  - SET: cell = `op_wdata`. Set dirty. Go to DONE.
  - RIGHT / LEFT: if dirty, go to WB; else go to GAP.
  - FLUSH: if dirty, go to WB; else go to DONE.
  - NOP: go to DONE.
- WB:
  - Drive `d_req` = 1 with WRITE, address = pointer, data = cell.
  - On `d_ack`: clear dirty, drop `d_req`.
  - Go to GAP for RIGHT/LEFT, or DONE for FLUSH.
- GAP (one cycle, `d_req` = 0):
  - RIGHT: pointer = (pointer == `d_mem_length`−1) ? 0 : pointer+1.
  - LEFT: pointer = (pointer == 0) ? `d_mem_length`−1 : pointer−1.
  - Then go to FETCH.
- DONE: `op_ack` = 1 for one cycle, then IDLE.
- Memory handshake:
  - `d_req`, `d_dir`, `d_addr` and `d_wdata` are held stable until `d_ack`.
  - `d_req` is low for at least one cycle between transactions. This is required because the memory's ready flag stays set for one cycle after a request.
- `op_req` is ignored outside IDLE. The core may present the next op in the cycle after `op_ack`.

## Timing
- Cycle N is the IDLE cycle in which the op is accepted.
- INC, DEC, SET, NOP, and FLUSH when clean: `op_ack` at N+1.
- RIGHT/LEFT when clean: GAP N+1, `d_req` N+2, `d_ack` N+3, `op_ack` N+4.
- RIGHT/LEFT when dirty: `d_req` (WRITE) N+1, `d_ack` N+2, GAP N+3, `d_req` (READ) N+4, `d_ack` N+5, `op_ack` N+6.
- FLUSH when dirty: `op_ack` at N+3.
- Memory stall: a late `d_ack` simply extends WB or FETCH; `d_req` stays high and the request is unchanged.
- Reset asserted mid-transaction: `d_req` and `op_ack` drop immediately. Dirty data is lost; this is an accepted loss.
- After reset release, `d_req` rises at the first clock edge.

## Configuration
- `D_CELL_WRITEBACK_EN` defined:
  - Write-back behaviour as above.
  - Memory is written only on RIGHT, LEFT and FLUSH.
- `D_CELL_WRITEBACK_EN` undefined (write-through):
  - INC, DEC and SET go IDLE→WB→DONE, with `op_ack` at N+3.
  - Dirty never survives an op.
  - RIGHT/LEFT always take the clean path.
  - FLUSH behaves as NOP.

## Test plan
- Reset, then memory cell 0 = 0x00: one READ at address 0; `cell_zero` = 1; no `op_ack`.
- INC ×3, DEC ×4 from 0: acks at 1-cycle latency, final `cell_value` = 0xFF. Write-back build: no `d_req`. Write-through build: 7 WRITEs.
- SET 0x41, then RIGHT at pointer 0: WRITE addr 0 data 0x41, GAP with `d_req` low, READ addr 1, `op_ack` at N+6.
- LEFT at pointer 0 with `d_mem_length` = 64: READ addr 63. Then RIGHT at pointer 63: READ addr 0.
- `d_ack` delayed 5 cycles during WB: request held stable, single write, correct completion.
- Assert `rst` during FETCH: `d_req` falls asynchronously; after release, pointer = 0 and a fresh READ at addr 0.
